// File: rtl/alu2_seq_pkg.sv
// Shared types and widths for the sequential ALU front end.
package alu2_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture
    } state_e;

    localparam int unsigned ALU_IN_W  = 10;
    localparam int unsigned ALU_OUT_W = 6;
    localparam int unsigned OPCNT_W   = 16;
    localparam int unsigned SETTLE_W  = 4;

    function automatic logic calc_parity(input logic [ALU_OUT_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/alu2_rsp_fifo.sv
// Pointer/count response FIFO; head entry is presented straight from storage flops.
module alu2_rsp_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             not_empty,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    // Pops against an empty FIFO are dropped.
    assign pop_eff = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop_eff);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign not_empty = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu2_seq_frontend.sv
// Registers operands into the ALU cone, waits a settle window, captures the result into a FIFO.
// Optional ALU2_SEQ_PARITY_EN adds a per-entry parity bit on rsp_parity.
module alu2_seq_frontend
    import alu2_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned RSP_DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ALU_IN_W-1:0]  req_operand,
    output logic [ALU_IN_W-1:0]  alu_pi,
    input  logic [ALU_OUT_W-1:0] alu_po,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_OUT_W-1:0] rsp_data,
    output logic [OPCNT_W-1:0]   op_count,
    output logic                 busy
`ifdef ALU2_SEQ_PARITY_EN
    ,
    output logic                 rsp_parity
`endif
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
`ifdef ALU2_SEQ_PARITY_EN
    localparam int unsigned FIFO_W = ALU_OUT_W + 1;
`else
    localparam int unsigned FIFO_W = ALU_OUT_W;
`endif

    state_e                state_q, state_d;
    logic [ALU_IN_W-1:0]   alu_pi_q, alu_pi_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [OPCNT_W-1:0]    op_count_q, op_count_d;
    logic                  push;
    logic [FIFO_W-1:0]     push_word;
    logic [FIFO_W-1:0]     head_word;
    logic [CNT_W-1:0]      fifo_count;

    always_comb begin
        state_d      = state_q;
        alu_pi_d     = alu_pi_q;
        settle_cnt_d = settle_cnt_q;
        op_count_d   = op_count_q;
        push         = 1'b0;
        req_ready    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Space is reserved at accept so the later capture can never overflow.
                req_ready = (fifo_count < RSP_DEPTH[CNT_W-1:0]);
                if (req_valid && req_ready) begin
                    alu_pi_d     = req_operand;
                    settle_cnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (settle_cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            StCapture: begin
                push       = 1'b1;
                op_count_d = op_count_q + OPCNT_W'(1);
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            alu_pi_q     <= '0;
            settle_cnt_q <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_pi_q     <= alu_pi_d;
            settle_cnt_q <= settle_cnt_d;
            op_count_q   <= op_count_d;
        end
    end

`ifdef ALU2_SEQ_PARITY_EN
    assign push_word  = {calc_parity(alu_po), alu_po};
    assign rsp_parity = head_word[ALU_OUT_W];
`else
    assign push_word  = alu_po;
`endif

    alu2_rsp_fifo #(
        .WIDTH(FIFO_W),
        .DEPTH(RSP_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_word),
        .pop      (rsp_ready),
        .count    (fifo_count),
        .not_empty(rsp_valid),
        .head_data(head_word)
    );

    assign rsp_data = head_word[ALU_OUT_W-1:0];
    assign alu_pi   = alu_pi_q;
    assign op_count = op_count_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu2_seq_frontend.sv
// Directed bench for alu2_seq_frontend; stub ALU is alu_po = alu_pi[5:0] ^ 6'h2A.
module tb_alu2_seq_frontend;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [9:0] req_operand, alu_pi;
    logic [5:0] alu_po, rsp_data;
    logic [15:0] op_count;

    logic       req_valid4, req_ready4, rsp_valid4, rsp_ready4, busy4;
    logic [9:0] req_operand4, alu_pi4;
    logic [5:0] alu_po4, rsp_data4;
    logic [15:0] op_count4;

`ifdef ALU2_SEQ_PARITY_EN
    logic rsp_parity, rsp_parity4;
`endif

    assign alu_po  = alu_pi[5:0] ^ 6'h2A;
    assign alu_po4 = alu_pi4[5:0] ^ 6'h2A;

    alu2_seq_frontend u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_operand(req_operand),
        .alu_pi     (alu_pi),
        .alu_po     (alu_po),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .op_count   (op_count),
        .busy       (busy)
`ifdef ALU2_SEQ_PARITY_EN
        ,
        .rsp_parity (rsp_parity)
`endif
    );

    alu2_seq_frontend #(
        .SETTLE_CYCLES(4)
    ) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid4),
        .req_ready  (req_ready4),
        .req_operand(req_operand4),
        .alu_pi     (alu_pi4),
        .alu_po     (alu_po4),
        .rsp_valid  (rsp_valid4),
        .rsp_ready  (rsp_ready4),
        .rsp_data   (rsp_data4),
        .op_count   (op_count4),
        .busy       (busy4)
`ifdef ALU2_SEQ_PARITY_EN
        ,
        .rsp_parity (rsp_parity4)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds the request until taken, returns at the negedge after accept.
    task automatic send(input logic [9:0] op, input int max_cyc);
        bit taken;
        taken       = 1'b0;
        req_valid   = 1'b1;
        req_operand = op;
        for (int i = 0; i < max_cyc && !taken; i++) begin
            taken = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check_eq("accept", 32'(taken), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_operand  = '0;
        rsp_ready    = 1'b0;
        req_valid4   = 1'b0;
        req_operand4 = '0;
        rsp_ready4   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data",  32'(rsp_data),  32'h0);
        check_eq("rst_op_count",  32'(op_count),  32'h0);
        check_eq("rst_alu_pi",    32'(alu_pi),    32'h0);

        // Single op, latency 3.
        rsp_ready = 1'b1;
        send(10'h3C5, 4);
        check_eq("t1_c1_alu_pi",    32'(alu_pi),    32'h3C5);
        check_eq("t1_c1_req_ready", 32'(req_ready), 32'd0);
        check_eq("t1_c1_busy",      32'(busy),      32'd1);
        check_eq("t1_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t1_c2_alu_pi",    32'(alu_pi),    32'h3C5);
        @(negedge clk);
        check_eq("t1_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t1_c3_rsp_data",  32'(rsp_data),  32'h2F);
        check_eq("t1_c3_op_count",  32'(op_count),  32'd1);
        check_eq("t1_c3_req_ready", 32'(req_ready), 32'd1);
        check_eq("t1_c3_busy",      32'(busy),      32'd0);
        @(negedge clk);
        check_eq("t1_c4_rsp_valid", 32'(rsp_valid), 32'd0);

        // SETTLE_CYCLES = 4 instance.
        rsp_ready4   = 1'b1;
        req_valid4   = 1'b1;
        req_operand4 = 10'h001;
        check_eq("t2_c0_req_ready", 32'(req_ready4), 32'd1);
        @(negedge clk);
        req_valid4 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_eq("t2_alu_pi",    32'(alu_pi4),    32'h001);
            check_eq("t2_req_ready", 32'(req_ready4), 32'd0);
            check_eq("t2_rsp_valid", 32'(rsp_valid4), 32'd0);
            @(negedge clk);
        end
        check_eq("t2_c6_rsp_valid", 32'(rsp_valid4), 32'd1);
        check_eq("t2_c6_rsp_data",  32'(rsp_data4),  32'h2B);
        check_eq("t2_c6_op_count",  32'(op_count4),  32'd1);

        // Back-pressure: two fill the FIFO, the third waits.
        rsp_ready = 1'b0;
        send(10'h000, 4);
        send(10'h015, 8);
        req_valid   = 1'b1;
        req_operand = 10'h3FF;
        for (int c = 0; c < 6; c++) begin
            check_eq("t3_blocked_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check_eq("t3_full_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t3_full_busy",      32'(busy),      32'd0);
        check_eq("t3_head0",          32'(rsp_data),  32'h2A);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_head1",          32'(rsp_data),  32'h3F);
        check_eq("t3_ready_after_pop", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("t3_drained",   32'(rsp_valid), 32'd0);
        check_eq("t3_alu_pi",    32'(alu_pi),    32'h3FF);
        check_eq("t3_busy",      32'(busy),      32'd1);
        repeat (2) @(negedge clk);
        check_eq("t3_third_valid", 32'(rsp_valid), 32'd1);
        check_eq("t3_third_data",  32'(rsp_data),  32'h15);
        check_eq("t3_op_count",    32'(op_count),  32'd4);
        @(negedge clk);
        check_eq("t3_empty", 32'(rsp_valid), 32'd0);

        // Simultaneous push and pop at count 1.
        rsp_ready = 1'b0;
        send(10'h012, 4);
        @(negedge clk);
        @(negedge clk);
        check_eq("t4_first_valid", 32'(rsp_valid), 32'd1);
        check_eq("t4_first_data",  32'(rsp_data),  32'h38);
        send(10'h3C5, 4);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("t4_second_valid", 32'(rsp_valid), 32'd1);
        check_eq("t4_second_data",  32'(rsp_data),  32'h2F);
        check_eq("t4_req_ready",    32'(req_ready), 32'd1);
        check_eq("t4_op_count",     32'(op_count),  32'd6);
        @(negedge clk);
        check_eq("t4_count_was_1", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Reset in SETTLE with an entry already queued.
        send(10'h015, 4);
        @(negedge clk);
        @(negedge clk);
        check_eq("t5_queued_data", 32'(rsp_data), 32'h3F);
        check_eq("t5_op_count",    32'(op_count), 32'd7);
        send(10'h3C5, 4);
        check_eq("t5_in_settle", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_busy",      32'(busy),      32'd0);
        check_eq("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5_rst_rsp_data",  32'(rsp_data),  32'h0);
        check_eq("t5_rst_op_count",  32'(op_count),  32'h0);
        check_eq("t5_rst_alu_pi",    32'(alu_pi),    32'h0);
        check_eq("t5_rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("t5_no_rsp",      32'(rsp_valid), 32'd0);
            check_eq("t5_no_capture",  32'(op_count),  32'd0);
        end

        // op_count wrap.
        force u_dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut.op_count_q;
        check_eq("t6_preload", 32'(op_count), 32'hFFFF);
        rsp_ready = 1'b1;
        send(10'h3C5, 4);
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_wrap",      32'(op_count), 32'h0);
        check_eq("t6_rsp_data",  32'(rsp_data), 32'h2F);
`ifdef ALU2_SEQ_PARITY_EN
        check_eq("t6_rsp_parity", 32'(rsp_parity), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu2_seq_frontend.md
# alu2_seq_frontend

Sequential front end for the combinational 10-in/6-out ALU cone. Accepts operand words through a valid/ready request port and drives them onto the ALU inputs. Holds the inputs stable for a programmable settle window, then captures the ALU outputs. Delivers captured results through a buffered valid/ready response port. It is both the upstream driver and the downstream consumer of the ALU cone, so the combinational block never sees an unregistered input or an unsampled output.

## Interface
Parameters:
- SETTLE_CYCLES, default 1, number of cycles the ALU inputs are held before capture; legal range 1..15.
- RSP_DEPTH, default 2, response FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request operand valid.
- req_ready  out  1  block can accept a request this cycle.
- req_operand  in  10  operand word; bit k maps to ALU input pik.
- alu_pi  out  10  registered drive to ALU inputs pi0..pi9.
- alu_po  in  6  ALU outputs po0..po5.
- rsp_valid  out  1  response FIFO non-empty.
- rsp_ready  in  1  consumer pops the head entry.
- rsp_data  out  6  head-of-FIFO captured result.
- op_count  out  16  completed captures, wrapping.
- busy  out  1  state is not IDLE.

## Operation
- FSM states are IDLE, SETTLE and CAPTURE.
- IDLE:
  - req_ready = (fifo_count < RSP_DEPTH).
  - On req_valid & req_ready: alu_pi <= req_operand, settle_cnt <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - alu_pi is held and req_ready = 0.
  - If settle_cnt == 0, go to CAPTURE; otherwise settle_cnt decrements.
- CAPTURE:
  - Push alu_po into the FIFO, increment op_count, go to IDLE.
  - alu_pi keeps its value until the next accept; it is never cleared between operations.
- The FIFO space check happens only at accept. One operation is in flight at most, and only the capture pushes, so a CAPTURE push never meets a full FIFO. No overflow path exists.
- Pop on rsp_valid & rsp_ready. A simultaneous push and pop leaves fifo_count unchanged, and the data order is preserved.
- rsp_ready while empty is ignored. req_valid outside IDLE is ignored, and the request must be held by the producer.
- op_count wraps 16'hFFFF -> 16'h0000.
- Reset, including mid-SETTLE or mid-CAPTURE, forces the following and discards any in-flight operation:
  - state IDLE, alu_pi 0, settle_cnt 0;
  - FIFO empty, rsp_valid 0, rsp_data 0;
  - op_count 0, busy 0;
  - req_ready = 1 combinationally after reset.

## Timing
- Request handshake sampled at the end of cycle 0.
- alu_pi shows the new operand in cycles 1..SETTLE_CYCLES+1.
- alu_po is sampled at the end of cycle SETTLE_CYCLES+1.
- rsp_valid rises in cycle SETTLE_CYCLES+2 if the FIFO was empty. Latency is SETTLE_CYCLES+2 cycles, 3 at the default.
- req_ready can next be high in cycle SETTLE_CYCLES+2. Peak throughput is one operation per SETTLE_CYCLES+2 cycles.
- req_ready depends only on state and fifo_count, never on req_valid. rsp_valid and rsp_data are registered.

## Configuration
- ALU2_SEQ_PARITY_EN:
  - When defined, an extra output rsp_parity (1 bit) is present.
  - Each FIFO entry widens to 7 bits, and the parity bit is computed at push as XOR of alu_po[5:0].
  - rsp_parity is reset to 0.
  - When undefined, the port and the extra storage bit are absent. All other behaviour is identical.

## Structure
- Shared package alu2_seq_pkg holds:
  - state enum {IDLE, SETTLE, CAPTURE};
  - ALU_IN_W = 10, ALU_OUT_W = 6, OPCNT_W = 16;
  - settle counter width of 4.
- One sub-module, alu2_rsp_fifo: parameterised width and depth, pointer/count based, with the same clk and rst.

## Test plan
Bench stub: alu_po = req_operand-path alu_pi[5:0] ^ 6'h2A. Default parameters unless stated.
- Single op, operand 10'h3C5, rsp_ready=1 → rsp_valid high in cycle 3 with rsp_data 6'h2F. op_count 1.
- SETTLE_CYCLES=4, operand 10'h001 → alu_pi stable cycles 1..5, rsp_data 6'h2B in cycle 6, req_ready low cycles 1..5.
- Back-pressure: rsp_ready=0, three requests 10'h000, 10'h015, 10'h3FF offered back-to-back:
  - the first two are accepted and req_ready stays low with FIFO full;
  - raising rsp_ready pops 6'h2A then 6'h3F, and the third is then accepted and returns 6'h15.
- Simultaneous pop and push with count 1 → count stays 1 and order is preserved.
- Reset asserted in SETTLE → all outputs go to reset values immediately, and no response is ever produced for that operand.
- op_count preloaded via 65535 ops or force to 16'hFFFF, one more op → 16'h0000. With ALU2_SEQ_PARITY_EN, result 6'h2F → rsp_parity 1.
